// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the round-robin memory arbiter.
package mem_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int MEM_ADDR_W  = 12;
    localparam int MEM_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Latched command, sized for the 4Kx8 memory this arbiter fronts.
    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && valid[j]) begin
                any      = 1'b1;
                idx      = IDX_W'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters.
// Optional ack timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic                           rsp_err,
    output logic                           mem_readEnable,
    output logic                           mem_writeEnable,
    output logic [ADDR_W-1:0]              mem_rwAddr,
    output logic [DATA_W-1:0]              mem_writeData_in,
    input  logic [DATA_W-1:0]              mem_readData_out,
    input  logic                           mem_ack
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         state, nextState;
    logic [IDX_W-1:0]   ptr, gIdx, grantIdx;
    logic [NUM_REQ-1:0] grant;
    logic               anyValid, accept, done, timeout;
    mem_cmd_t           cmd;
    logic [DATA_W-1:0]  rdata;
    logic               err;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) uRr (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grantIdx),
        .any   (anyValid)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] busyCnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                busyCnt <= '0;
        else if (accept)           busyCnt <= '0;
        else if (state == BUSY)    busyCnt <= busyCnt + 1'b1;
    end

    // Last BUSY cycle is the TIMEOUT-th; an ack in that cycle still wins.
    assign timeout = (state == BUSY) && (busyCnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (anyValid) begin
                nextState = BUSY;
                accept    = 1'b1;
            end
            BUSY: if (mem_ack || timeout) begin
                nextState = RESP;
                done      = 1'b1;
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr             <= '0;
            gIdx            <= '0;
            cmd             <= '0;
            rdata           <= '0;
            err             <= 1'b0;
            mem_readEnable  <= 1'b0;
            mem_writeEnable <= 1'b0;
        end else begin
            if (accept) begin
                gIdx            <= grantIdx;
                cmd.write       <= req_write[grantIdx];
                cmd.addr        <= req_addr[grantIdx];
                cmd.wdata       <= req_wdata[grantIdx];
                rdata           <= '0;
                err             <= 1'b0;
                mem_readEnable  <= ~req_write[grantIdx];
                mem_writeEnable <= req_write[grantIdx];
            end
            if (done) begin
                mem_readEnable  <= 1'b0;
                mem_writeEnable <= 1'b0;
                if (mem_ack) begin
                    if (!cmd.write) rdata <= mem_readData_out;
                end else begin
                    err <= 1'b1;
                end
            end
            if (state == RESP)
                ptr <= (gIdx == IDX_W'(NUM_REQ - 1)) ? '0 : gIdx + 1'b1;
        end
    end

    // Ready is gated by reset so nothing is offered while the block is held.
    assign req_ready        = (accept && reset) ? grant : '0;
    assign rsp_valid        = (state == RESP) ? (NUM_REQ'(1) << gIdx) : '0;
    assign rsp_rdata        = (state == RESP) ? rdata : '0;
    assign rsp_err          = (state == RESP) && err;
    assign mem_rwAddr       = cmd.addr;
    assign mem_writeData_in = cmd.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read/write, RR order, reset abort, timeout.
module tb_mem_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;

    logic                           clock = 1'b0;
    logic                           reset = 1'b0;
    logic [NUM_REQ-1:0]             req_valid = '0;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_write = '0;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]              rsp_rdata;
    logic                           rsp_err;
    logic                           mem_readEnable, mem_writeEnable;
    logic [ADDR_W-1:0]              mem_rwAddr;
    logic [DATA_W-1:0]              mem_writeData_in;
    logic [DATA_W-1:0]              mem_readData_out = '0;
    logic                           mem_ack = 1'b0;

    int vectors = 0;
    int errors  = 0;
    int hiCnt;
    int sawRsp;
    logic [NUM_REQ-1:0] rspSeen;
    logic               errSeen;
    logic [DATA_W-1:0]  rdSeen;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_readEnable(mem_readEnable), .mem_writeEnable(mem_writeEnable),
        .mem_rwAddr(mem_rwAddr), .mem_writeData_in(mem_writeData_in),
        .mem_readData_out(mem_readData_out), .mem_ack(mem_ack)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 0);
        check({tag, "_rsp"},   32'(rsp_valid), 0);
        check({tag, "_ren"},   32'(mem_readEnable), 0);
        check({tag, "_wen"},   32'(mem_writeEnable), 0);
        check({tag, "_addr"},  32'(mem_rwAddr), 0);
        check({tag, "_rdata"}, 32'(rsp_rdata), 0);
        check({tag, "_err"},   32'(rsp_err), 0);
    endtask

    initial begin
        // Reset state
        req_valid = 4'hF;
        tick(); tick();
        checkIdleOutputs("rst");
        req_valid = '0;
        reset = 1'b1;
        tick();

        // 1: single read, ack on the third enable cycle
        req_addr[0] = 12'h0A5;
        req_valid   = 4'b0001;
        #1 check("t1_ready", 32'(req_ready), 32'h1);
        tick(); req_valid = '0;
        #1 check("t1_ren_c1", 32'(mem_readEnable), 1);
        check("t1_wen", 32'(mem_writeEnable), 0);
        check("t1_addr", 32'(mem_rwAddr), 32'h0A5);
        tick(); check("t1_ren_c2", 32'(mem_readEnable), 1);
        tick(); check("t1_ren_c3", 32'(mem_readEnable), 1);
        mem_ack = 1'b1; mem_readData_out = 8'h3C;
        tick(); mem_ack = 1'b0; mem_readData_out = '0;
        #1 check("t1_ren_off", 32'(mem_readEnable), 0);
        check("t1_rsp", 32'(rsp_valid), 32'h1);
        check("t1_rdata", 32'(rsp_rdata), 32'h3C);
        check("t1_err", 32'(rsp_err), 0);
        tick(); check("t1_rsp_pulse", 32'(rsp_valid), 0);

        // 2: single write from requester 2, ack immediately
        req_write[2] = 1'b1; req_addr[2] = 12'hFFF; req_wdata[2] = 8'h81;
        req_valid = 4'b0100;
        #1 check("t2_ready", 32'(req_ready), 32'h4);
        tick(); req_valid = '0; mem_ack = 1'b1;
        #1 check("t2_wen", 32'(mem_writeEnable), 1);
        check("t2_ren", 32'(mem_readEnable), 0);
        check("t2_wdata", 32'(mem_writeData_in), 32'h81);
        check("t2_addr", 32'(mem_rwAddr), 32'hFFF);
        tick(); mem_ack = 1'b0;
        #1 check("t2_wen_off", 32'(mem_writeEnable), 0);
        check("t2_rsp", 32'(rsp_valid), 32'h4);
        check("t2_rdata", 32'(rsp_rdata), 0);
        tick();
        req_write[2] = 1'b0;

        // Stray ack while idle must not produce a response
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        #1 check("stray_rsp", 32'(rsp_valid), 0);
        tick(); check("stray_rsp2", 32'(rsp_valid), 0);

        // 3: all four valid from reset, ack one cycle after enable
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) req_addr[i] = 12'(12'h100 + i);
        req_valid = 4'hF;
        #1;
        for (int n = 0; n < 5; n++) begin
            check("t3_ready", 32'(req_ready), 32'(1 << (n % 4)));
            tick();
            check("t3_addr", 32'(mem_rwAddr), 32'(12'h100 + (n % 4)));
            mem_ack = 1'b1; mem_readData_out = 8'(8'h50 + n);
            tick(); mem_ack = 1'b0;
            #1 check("t3_rsp", 32'(rsp_valid), 32'(1 << (n % 4)));
            check("t3_rdata", 32'(rsp_rdata), 32'(8'h50 + n));
            tick();
        end
        // Serve requester 1 alone so the pointer lands on 2
        req_valid = 4'b0010;
        #1 check("t4_pre_ready", 32'(req_ready), 32'h2);
        tick(); req_valid = '0; mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        tick();

        // 4: ptr=2 with requesters 1 and 3 pending -> 3 then 1
        req_valid = 4'b1010;
        #1 check("t4_first", 32'(req_ready), 32'h8);
        tick(); req_valid = 4'b0010; mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        #1 check("t4_rsp3", 32'(rsp_valid), 32'h8);
        tick(); check("t4_second", 32'(req_ready), 32'h2);
        tick(); req_valid = '0; mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        #1 check("t4_rsp1", 32'(rsp_valid), 32'h2);
        tick();

        // 5: reset mid-BUSY drops the transaction and rewinds the pointer
        req_valid = 4'b0100;
        #1 check("t5_ready", 32'(req_ready), 32'h4);
        tick(); req_valid = '0;
        #1 check("t5_ren_on", 32'(mem_readEnable), 1);
        #1 reset = 1'b0;
        #1 check("t5_ren_async", 32'(mem_readEnable), 0);
        req_valid = 4'hF;
        #1 check("t5_ready_rst", 32'(req_ready), 0);
        tick(); check("t5_rsp_a", 32'(rsp_valid), 0);
        tick(); check("t5_rsp_b", 32'(rsp_valid), 0);
        reset = 1'b1;
        #1 check("t5_regrant", 32'(req_ready), 32'h1);
        tick(); req_valid = '0; mem_ack = 1'b1;
        tick(); mem_ack = 1'b0;
        #1 check("t5_rsp0", 32'(rsp_valid), 32'h1);
        tick();

        // 6: no ack ever arrives
        req_addr[1] = 12'h123; mem_readData_out = 8'hEE;
        req_valid = 4'b0010;
        #1 check("t6_ready", 32'(req_ready), 32'h2);
        tick(); req_valid = '0;
        hiCnt = 0; sawRsp = 0; rspSeen = '0; errSeen = 1'b0; rdSeen = '0;
        for (int c = 0; c < 100; c++) begin
            if (mem_readEnable) hiCnt++;
            if (rsp_valid != '0) begin
                sawRsp++; rspSeen = rsp_valid; errSeen = rsp_err; rdSeen = rsp_rdata;
            end
            tick();
        end
`ifdef MEM_ARB_TIMEOUT_EN
        check("t6_hi_cycles", 32'(hiCnt), 16);
        check("t6_rsp_count", 32'(sawRsp), 1);
        check("t6_rsp", 32'(rspSeen), 32'h2);
        check("t6_err", 32'(errSeen), 1);
        check("t6_rdata", 32'(rdSeen), 0);
`else
        check("t6_hi_cycles", 32'(hiCnt), 100);
        check("t6_no_rsp", 32'(sawRsp), 0);
        check("t6_still_busy", 32'(mem_readEnable), 1);
        check("t6_addr_held", 32'(mem_rwAddr), 32'h123);
`endif
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
